// File: rtl/axi_sram_slave.sv
// AXI3-style slave backed by a 2**ADDR_W x 32b word SRAM; independent read/write FSMs, one burst each.
// Define AXI_SLV_STALL_EN to add LFSR-driven ready/beat bubbles for master back-pressure testing.
module axi_sram_slave #(
   parameter int          ADDR_W     = 12,
   parameter int          RD_LAT     = 1,
   parameter logic [15:0] STALL_SEED = 16'hACE1
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic [3:0]  arid,
   input  logic [31:0] araddr,
   input  logic [7:0]  arlen,
   input  logic [2:0]  arsize,
   input  logic [1:0]  arburst,
   input  logic [1:0]  arlock,
   input  logic [3:0]  arcache,
   input  logic [2:0]  arprot,
   input  logic        arvalid,
   output logic        arready,
   output logic [3:0]  rid,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rlast,
   output logic        rvalid,
   input  logic        rready,
   input  logic [3:0]  awid,
   input  logic [31:0] awaddr,
   input  logic [3:0]  awlen,
   input  logic [2:0]  awsize,
   input  logic [1:0]  awburst,
   input  logic [1:0]  awlock,
   input  logic [3:0]  awcache,
   input  logic [2:0]  awprot,
   input  logic        awvalid,
   output logic        awready,
   input  logic [3:0]  wid,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wlast,
   input  logic        wvalid,
   output logic        wready,
   output logic [3:0]  bid,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready
);

   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

   localparam int WAIT_INIT = (RD_LAT > 1) ? RD_LAT - 2 : 0;

   logic [31:0] mem [2**ADDR_W];
   logic        stall;
   logic        unused_ok;

   function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] size,
                                             input logic [7:0] len, input logic [1:0] burst);
      logic [31:0] step;
      logic [31:0] mask;
      logic [31:0] inc;
      step = 32'd1 << size;
      mask = ((32'(len) + 32'd1) << size) - 32'd1;
      inc  = a + step;
      case (burst)
         2'b00:   return a;
         2'b10:   return (a & ~mask) | (inc & mask);
         default: return inc;
      endcase
   endfunction

`ifdef AXI_SLV_STALL_EN
   logic [15:0] lfsr;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) lfsr <= STALL_SEED;
      else          lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end

   assign stall     = lfsr[0];
   assign unused_ok = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};
`else
   assign stall     = 1'b0;
   assign unused_ok = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid, STALL_SEED};
`endif

   // ---------------- read channel ----------------
   r_state_t    r_state, r_state_nx;
   logic        arready_q;
   logic [31:0] r_addr;
   logic [7:0]  r_len, r_beat;
   logic [2:0]  r_size;
   logic [1:0]  r_burst;
   logic [15:0] r_wait;
   logic        ar_hs, r_load;
   logic [31:0] ld_addr;
   logic [7:0]  ld_len, ld_beat;
   logic [2:0]  ld_size;
   logic [1:0]  ld_burst;

   assign arready = arready_q & ~stall;
   assign rresp   = 2'b00;

   always_comb begin
      r_state_nx = r_state;
      ar_hs      = 1'b0;
      r_load     = 1'b0;
      case (r_state)
         R_IDLE: if (arvalid && arready) begin
            ar_hs = 1'b1;
            if (RD_LAT == 1) begin
               r_load     = 1'b1;
               r_state_nx = R_DATA;
            end else begin
               r_state_nx = R_WAIT;
            end
         end
         R_WAIT: if (r_wait == 16'd0 && !stall) begin
            r_load     = 1'b1;
            r_state_nx = R_DATA;
         end
         R_DATA: begin
            // a stalled follow-on beat leaves rvalid low until the LFSR allows the load
            if (rvalid && rready) begin
               if (rlast)       r_state_nx = R_IDLE;
               else if (!stall) r_load     = 1'b1;
            end else if (!rvalid && !stall) begin
               r_load = 1'b1;
            end
         end
         default: r_state_nx = R_IDLE;
      endcase
   end

   // the first beat of an RD_LAT=1 burst is loaded straight from the ar channel
   always_comb begin
      ld_addr  = r_addr;
      ld_len   = r_len;
      ld_size  = r_size;
      ld_burst = r_burst;
      ld_beat  = r_beat;
      if (r_state == R_IDLE) begin
         ld_addr  = araddr;
         ld_len   = arlen;
         ld_size  = arsize;
         ld_burst = arburst;
         ld_beat  = '0;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state   <= R_IDLE;
         arready_q <= 1'b0;
         r_addr    <= '0;
         r_len     <= '0;
         r_size    <= '0;
         r_burst   <= '0;
         r_beat    <= '0;
         r_wait    <= '0;
         rid       <= '0;
         rdata     <= '0;
         rlast     <= 1'b0;
         rvalid    <= 1'b0;
      end else begin
         r_state   <= r_state_nx;
         arready_q <= (r_state_nx == R_IDLE);
         if (ar_hs) begin
            rid     <= arid;
            r_addr  <= araddr;
            r_len   <= arlen;
            r_size  <= arsize;
            r_burst <= arburst;
            r_beat  <= '0;
            r_wait  <= 16'(WAIT_INIT);
         end else if (r_state == R_WAIT && r_wait != 16'd0) begin
            r_wait <= r_wait - 16'd1;
         end
         if (r_load) begin
            rdata  <= mem[ld_addr[ADDR_W+1:2]];
            rlast  <= (ld_beat == ld_len);
            rvalid <= 1'b1;
            r_addr <= next_addr(ld_addr, ld_size, ld_len, ld_burst);
            r_beat <= ld_beat + 8'd1;
         end else if (rvalid && rready) begin
            rvalid <= 1'b0;
            rlast  <= 1'b0;
         end
      end
   end

   // ---------------- write channel ----------------
   w_state_t    w_state, w_state_nx;
   logic        awready_q, wready_q;
   logic [3:0]  w_id, w_len, w_beat;
   logic [31:0] w_addr;
   logic [2:0]  w_size;
   logic [1:0]  w_burst;
   logic        w_err;
   logic        aw_hs, w_hs, w_final, beat_err;

   assign awready  = awready_q & ~stall;
   assign wready   = wready_q & ~stall;
   assign aw_hs    = awvalid && awready;
   assign w_hs     = wvalid && wready;
   assign w_final  = (w_beat == w_len);
   assign beat_err = (wlast != w_final);

   always_comb begin
      w_state_nx = w_state;
      case (w_state)
         W_IDLE:  if (aw_hs)             w_state_nx = W_DATA;
         W_DATA:  if (w_hs && w_final)   w_state_nx = W_RESP;
         W_RESP:  if (bvalid && bready)  w_state_nx = W_IDLE;
         default:                        w_state_nx = W_IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         w_state   <= W_IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         w_id      <= '0;
         w_addr    <= '0;
         w_len     <= '0;
         w_size    <= '0;
         w_burst   <= '0;
         w_beat    <= '0;
         w_err     <= 1'b0;
         bid       <= '0;
         bresp     <= '0;
         bvalid    <= 1'b0;
      end else begin
         w_state   <= w_state_nx;
         awready_q <= (w_state_nx == W_IDLE);
         wready_q  <= (w_state_nx == W_DATA);
         if (aw_hs) begin
            w_id    <= awid;
            w_addr  <= awaddr;
            w_len   <= awlen;
            w_size  <= awsize;
            w_burst <= awburst;
            w_beat  <= '0;
            w_err   <= 1'b0;
         end
         if (w_hs) begin
            w_addr <= next_addr(w_addr, w_size, {4'b0, w_len}, w_burst);
            w_beat <= w_beat + 4'd1;
            w_err  <= w_err | beat_err;
            if (w_final) begin
               bvalid <= 1'b1;
               bid    <= w_id;
               bresp  <= (w_err | beat_err) ? 2'b10 : 2'b00;
            end
         end else if (bvalid && bready) begin
            bvalid <= 1'b0;
         end
      end
   end

   always_ff @(posedge aclk) begin
      if (w_hs) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (wstrb[i]) mem[w_addr[ADDR_W+1:2]][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed and randomised self-checking bench for axi_sram_slave (default RD_LAT=1 build).
module tb_axi_sram_slave;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic [1:0]  arlock;
   logic [3:0]  arcache;
   logic [2:0]  arprot;
   logic        arvalid, arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast, rvalid, rready;
   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [3:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic [1:0]  awlock;
   logic [3:0]  awcache;
   logic [2:0]  awprot;
   logic        awvalid, awready;
   logic [3:0]  wid;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast, wvalid, wready;
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid, bready;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   logic [31:0] rd_data [16];
   logic        rd_last [16];
   logic [3:0]  rd_id   [16];
   logic [31:0] wr_data [16];
   logic [3:0]  wr_strb [16];
   logic [3:0]  got_bid;
   logic [1:0]  got_bresp;
   logic [31:0] model   [4096];

   axi_sram_slave #(.ADDR_W(12), .RD_LAT(1), .STALL_SEED(16'hACE1)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
      .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   always #5 aclk = ~aclk;

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation still running, required finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
      end
   endtask

   // Bench-side address sequence, written independently of the RTL's step/mask form.
   function automatic logic [31:0] beat_addr(input logic [31:0] a, input int unsigned n,
                                             input int unsigned len, input logic [1:0] burst);
      logic [31:0] blk, base;
      case (burst)
         2'b00: return a;
         2'b10: begin
            blk  = (len + 1) * 4;
            base = a - (a % blk);
            return base + ((a - base + n * 4) % blk);
         end
         default: return a + n * 4;
      endcase
   endfunction

   // All channel tasks are entered and return 1 time unit after a rising edge.
   task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, output time t_hs);
      bit done = 1'b0;
      t_hs = 0;
      arid = id; araddr = addr; arlen = len; arsize = 3'd2; arburst = burst; arvalid = 1'b1;
      for (int unsigned n = 0; n < 200 && !done; n++) begin
         @(negedge aclk);
         if (arready) begin
            @(posedge aclk); t_hs = $time; #1; done = 1'b1;
         end
      end
      arvalid = 1'b0;
      if (!done) check("ar_handshake_timeout", done, 1);
   endtask

   task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [1:0] burst, output time t_hs);
      bit done = 1'b0;
      t_hs = 0;
      awid = id; awaddr = addr; awlen = len; awsize = 3'd2; awburst = burst; awvalid = 1'b1;
      for (int unsigned n = 0; n < 200 && !done; n++) begin
         @(negedge aclk);
         if (awready) begin
            @(posedge aclk); t_hs = $time; #1; done = 1'b1;
         end
      end
      awvalid = 1'b0;
      if (!done) check("aw_handshake_timeout", done, 1);
   endtask

   task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last,
                         output time t_hs);
      bit done = 1'b0;
      t_hs = 0;
      wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
      for (int unsigned n = 0; n < 200 && !done; n++) begin
         @(negedge aclk);
         if (wready) begin
            @(posedge aclk); t_hs = $time; #1; done = 1'b1;
         end
      end
      wvalid = 1'b0; wlast = 1'b0;
      if (!done) check("w_handshake_timeout", done, 1);
   endtask

   task automatic b_wait();
      bit done = 1'b0;
      bready = 1'b1;
      for (int unsigned n = 0; n < 200 && !done; n++) begin
         @(negedge aclk);
         if (bvalid) begin
            got_bid = bid; got_bresp = bresp;
            @(posedge aclk); #1; done = 1'b1;
         end
      end
      bready = 1'b0;
      if (!done) check("b_response_timeout", done, 1);
   endtask

   task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input int unsigned len,
                              input logic [1:0] burst, input logic [15:0] last_mask);
      time t;
      aw_send(id, addr, 4'(len), burst, t);
      for (int unsigned i = 0; i <= len; i++) w_beat(wr_data[i], wr_strb[i], last_mask[i], t);
      b_wait();
   endtask

   // mode 0: rready held, 1: toggled starting high, 2: random 3/4 duty
   task automatic r_collect(input int unsigned n, input int unsigned mode, output int unsigned lat);
      int unsigned beats = 0;
      int unsigned cyc   = 0;
      bit          hold  = 1'b0;
      logic [31:0] h_data;
      logic [3:0]  h_id;
      logic        h_last;
      lat = 0;
      while (beats < n && cyc < 400) begin
         @(negedge aclk);
         cyc++;
         if (hold) check("r_payload_hold", {rvalid, rid, rlast, rdata}, {1'b1, h_id, h_last, h_data});
         if (rvalid && lat == 0) lat = cyc;
         case (mode)
            0:       rready = 1'b1;
            1:       rready = (cyc % 2 == 1);
            default: rready = ($urandom % 4) != 0;
         endcase
         if (rvalid && rready) begin
            rd_data[beats] = rdata; rd_last[beats] = rlast; rd_id[beats] = rid;
            beats++;
         end
         hold = rvalid && !rready;
         h_data = rdata; h_id = rid; h_last = rlast;
      end
      if (beats < n) check("r_beat_timeout", beats, n);
      @(posedge aclk); #1;
      rready = 1'b0;
   endtask

   initial begin
      time         t1, t2, t3;
      int unsigned lat, len, op, word;
      logic [1:0]  burst;
      logic [3:0]  id;
      logic [31:0] addr, a;

      aresetn = 1'b0;
      {arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid} = '0;
      {awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid} = '0;
      {wid, wdata, wstrb, wlast, wvalid, rready, bready} = '0;
      repeat (2) @(posedge aclk);
      #1;
      check("rst_ctrl", {arready, awready, wready, rvalid, rlast, bvalid}, 6'b0);
      check("rst_payload", {rdata, rid, rresp, bid, bresp}, 44'b0);
      @(negedge aclk) aresetn = 1'b1;
      @(posedge aclk); #1;
      check("arready_after_rst", arready, 1);
      check("awready_after_rst", awready, 1);
      check("wready_idle", wready, 0);

      // single write then read-back
      wr_data[0] = 32'hDEADBEEF; wr_strb[0] = 4'hF;
      write_burst(4'h5, 32'h100, 0, 2'b01, 16'h0001);
      check("single_bid", got_bid, 4'h5);
      check("single_bresp", got_bresp, 2'b00);
      ar_send(4'h3, 32'h100, 8'd0, 2'b01, t1);
      r_collect(1, 0, lat);
      check("single_rdata", rd_data[0], 32'hDEADBEEF);
      check("single_rlast", rd_last[0], 1);
      check("single_rid", rd_id[0], 4'h3);
      check("single_rd_latency", lat, 1);
      check("rvalid_low_after_last", rvalid, 0);
      check("arready_after_last", arready, 1);

      // INCR x4 with toggling rready
      for (int unsigned i = 0; i < 4; i++) begin wr_data[i] = 32'hA500_0200 + 4 * i; wr_strb[i] = 4'hF; end
      write_burst(4'h1, 32'h200, 3, 2'b01, 16'h0008);
      check("incr_wr_bresp", got_bresp, 2'b00);
      ar_send(4'h9, 32'h200, 8'd3, 2'b01, t1);
      r_collect(4, 1, lat);
      check("incr_b0", rd_data[0], 32'hA500_0200);
      check("incr_b1", rd_data[1], 32'hA500_0204);
      check("incr_b2", rd_data[2], 32'hA500_0208);
      check("incr_b3", rd_data[3], 32'hA500_020C);
      check("incr_rlast_pattern", {rd_last[0], rd_last[1], rd_last[2], rd_last[3]}, 4'b0001);

      // WRAP x4 from 0x38 inside the 16-byte block at 0x30
      for (int unsigned i = 0; i < 4; i++) begin wr_data[i] = 32'h1111_0030 + 4 * i; wr_strb[i] = 4'hF; end
      write_burst(4'h2, 32'h30, 3, 2'b01, 16'h0008);
      ar_send(4'h4, 32'h38, 8'd3, 2'b10, t1);
      r_collect(4, 0, lat);
      check("wrap_b0", rd_data[0], 32'h1111_0038);
      check("wrap_b1", rd_data[1], 32'h1111_003C);
      check("wrap_b2", rd_data[2], 32'h1111_0030);
      check("wrap_b3", rd_data[3], 32'h1111_0034);

      // byte strobe merge, then wlast protocol errors
      wr_data[0] = 32'h11223344; wr_strb[0] = 4'hF;
      write_burst(4'h6, 32'h300, 0, 2'b01, 16'h0001);
      wr_data[0] = 32'h00AB0000; wr_strb[0] = 4'b0100;
      write_burst(4'h6, 32'h300, 0, 2'b01, 16'h0001);
      check("strb_bresp", got_bresp, 2'b00);
      ar_send(4'h6, 32'h300, 8'd0, 2'b01, t1);
      r_collect(1, 0, lat);
      check("strb_merge", rd_data[0], 32'h11AB3344);
      wr_data[0] = 32'h01010101; wr_data[1] = 32'h02020202; wr_strb[0] = 4'hF; wr_strb[1] = 4'hF;
      write_burst(4'hA, 32'h310, 1, 2'b01, 16'h0003);
      check("early_wlast_bresp", got_bresp, 2'b10);
      check("early_wlast_bid", got_bid, 4'hA);
      wr_data[0] = 32'h03030303;
      write_burst(4'hB, 32'h318, 0, 2'b01, 16'h0000);
      check("missing_wlast_bresp", got_bresp, 2'b10);
      ar_send(4'h0, 32'h310, 8'd2, 2'b01, t1);
      r_collect(3, 0, lat);
      check("err_burst_b0", rd_data[0], 32'h01010101);
      check("err_burst_b1", rd_data[1], 32'h02020202);
      check("missing_wlast_data", rd_data[2], 32'h03030303);

      // ar and aw accepted on the same edge; read returns data from before the write
      wr_data[0] = 32'h0BADF00D; wr_strb[0] = 4'hF;
      write_burst(4'h7, 32'h140, 0, 2'b01, 16'h0001);
      fork
         begin aw_send(4'h7, 32'h140, 4'd0, 2'b01, t1); w_beat(32'hCAFE1234, 4'hF, 1'b1, t3); b_wait(); end
         begin ar_send(4'h2, 32'h140, 8'd0, 2'b01, t2); r_collect(1, 0, lat); end
      join
      check("ar_aw_same_edge", t1, t2);
      check("concurrent_old_data", rd_data[0], 32'h0BADF00D);
      check("concurrent_bresp", got_bresp, 2'b00);
      // read beat loaded on the very edge that commits a write to that word
      fork
         begin aw_send(4'h7, 32'h140, 4'd0, 2'b01, t1); w_beat(32'h5555AAAA, 4'hF, 1'b1, t3); b_wait(); end
         begin @(posedge aclk); #1; ar_send(4'h2, 32'h140, 8'd0, 2'b01, t2); r_collect(1, 0, lat); end
      join
      check("wr_rd_same_edge", t3, t2);
      check("same_edge_old_data", rd_data[0], 32'hCAFE1234);
      ar_send(4'h2, 32'h140, 8'd0, 2'b01, t2);
      r_collect(1, 0, lat);
      check("committed_write_visible", rd_data[0], 32'h5555AAAA);

      // asynchronous reset in the middle of a read burst
      ar_send(4'h8, 32'h200, 8'd3, 2'b01, t1);
      @(negedge aclk);
      #2 aresetn = 1'b0;
      #1;
      check("midburst_rst_rvalid", rvalid, 0);
      check("midburst_rst_arready", arready, 0);
      repeat (2) @(posedge aclk);
      @(negedge aclk) aresetn = 1'b1;
      @(posedge aclk); #1;
      check("midburst_release_arready", arready, 1);
      repeat (4) @(negedge aclk);
      check("aborted_burst_silent", {rvalid, bvalid}, 2'b00);
      @(posedge aclk); #1;

      // fill 0x000-0x3FF, then random bursts against the scoreboard
      for (int unsigned blk = 0; blk < 16; blk++) begin
         for (int unsigned i = 0; i < 16; i++) begin
            wr_data[i] = $urandom; wr_strb[i] = 4'hF;
            model[blk * 16 + i] = wr_data[i];
         end
         write_burst(4'hF, 32'(blk * 64), 15, 2'b01, 16'h8000);
      end
      for (int unsigned it = 0; it < 1000; it++) begin
         op    = $urandom % 2;
         burst = 2'($urandom % 3);
         id    = 4'($urandom);
         len   = (burst == 2'b10) ? (2 << ($urandom % 4)) - 1 : $urandom % 8;
         word  = (burst == 2'b01) ? $urandom % 240 : $urandom % 256;
         addr  = 32'(word * 4) | ($urandom & 32'hFFFF_C000);
         if (op == 0) begin
            for (int unsigned i = 0; i <= len; i++) begin
               wr_data[i] = $urandom; wr_strb[i] = 4'($urandom);
               a = beat_addr(addr, i, len, burst);
               for (int unsigned b = 0; b < 4; b++)
                  if (wr_strb[i][b]) model[a[13:2]][8*b +: 8] = wr_data[i][8*b +: 8];
            end
            write_burst(id, addr, len, burst, 16'(1 << len));
            check("rand_bid", got_bid, id);
            check("rand_bresp", got_bresp, 2'b00);
         end else begin
            ar_send(id, addr, 8'(len), burst, t1);
            r_collect(len + 1, 2, lat);
            for (int unsigned i = 0; i <= len; i++) begin
               a = beat_addr(addr, i, len, burst);
               check("rand_rdata", rd_data[i], model[a[13:2]]);
               check("rand_rlast_rid", {rd_last[i], rd_id[i]}, {i == len, id});
            end
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
